ccrf_job_scheduler: RTL and testbench
=====================================

# ccrf_job_scheduler

Front-end scheduler sharing one CCRF wrapper kernel between several job requesters. It round-robin arbitrates job request streams and stamps each accepted job with a free job ID. Accepted jobs are forwarded on the kernel's 496-bit incoming job request stream. The 32-bit response message stream is routed back to the requester that owns the echoed job ID. It also drives the kernel's ap_start block-level handshake, and sits between the PS-side DMA/requester fabric and the CCRF wrapper.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- REQ_IDX_W, 2: clog2(NUM_REQ).
- JOB_ID_W, 4: job ID width; 2**JOB_ID_W jobs may be in flight.
- REQ_W, 496: job request word width.
- RSP_W, 32: response word width.
- aclk  in  1  sole clock, rising edge.
- areset  in  1  asynchronous, active-low reset.
- req_tvalid  in  NUM_REQ  per-requester job request valid.
- req_tready  out  NUM_REQ  per-requester accept.
- req_tdata  in  NUM_REQ*REQ_W  requester i occupies bits [i*REQ_W +: REQ_W].
- job_tvalid  out  1  to kernel incoming_job_requests TVALID.
- job_tready  in  1  from kernel TREADY.
- job_tdata  out  REQ_W  to kernel TDATA.
- rsp_in_tvalid  in  1  from kernel response_message_queue TVALID.
- rsp_in_tready  out  1  to kernel TREADY.
- rsp_in_tdata  in  RSP_W  kernel response; bits [JOB_ID_W-1:0] hold the echoed job ID.
- rsp_out_tvalid  out  NUM_REQ  per-requester response valid.
- rsp_out_tready  in  NUM_REQ  per-requester response ready.
- rsp_out_tdata  out  RSP_W  shared response data.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel ready.
- ap_idle  in  1  kernel idle (status only).
- inflight_count  out  JOB_ID_W+1  number of allocated job IDs.
- err_unknown_id  out  1  one-cycle pulse when a response carries an unallocated ID.

## Operation
- Control FSM states are S_RESET, S_START and S_RUN.
  - S_RESET: entered asynchronously on areset low. Leaves to S_START on the first clock after release.
  - S_START: ap_start=1. Moves to S_RUN on the cycle ap_ready is sampled 1.
  - S_RUN: ap_start stays 1 (free-running kernel). The block never leaves S_RUN except by reset.
- Requests are granted only in S_RUN.
- Arbitration is round-robin over req_tvalid. The search starts at rr_ptr.
- At most one grant per cycle.
- A grant requires all of:
  - a free job ID exists;
  - the job output register is empty, or is draining this cycle (job_tvalid & job_tready).
- req_tready[i] is 1 only for the granted requester. All other bits are 0.
- After a grant, rr_ptr becomes winner+1 mod NUM_REQ. With no grant, rr_ptr holds.
- ID allocation picks the lowest-numbered free ID.
  - The owner table entry for that ID is set to the winner's index.
  - The ID's busy bit is set.
- job_tdata is the winner's request word with bits [JOB_ID_W-1:0] overwritten by the allocated ID. All other bits pass unchanged.
- The response stage is a single register.
  - rsp_in_tready=1 when that register is empty, or is draining this cycle (rsp_out_tvalid[owner] & rsp_out_tready[owner]).
  - On accept, the ID is looked up.
  - If the ID is busy: register the data and owner, and clear the busy bit.
  - If the ID is not busy: discard the word, load nothing, and pulse err_unknown_id on the next cycle.
- rsp_out_tvalid is one-hot at the owner index, or all zeros.
- Simultaneous allocate and free in one cycle:
  - both take effect and inflight_count is unchanged;
  - an ID freed in cycle N is allocatable from cycle N+1.
- Full (all IDs busy): no grants and req_tready=0. The response path keeps running.
- Reset mid-operation:
  - all busy bits, the owner table, registers and rr_ptr are cleared;
  - in-flight jobs are abandoned;
  - responses for them after reset raise err_unknown_id.
- Reset values: ap_start 0, req_tready 0, job_tvalid 0, job_tdata 0, rsp_in_tready 0, rsp_out_tvalid 0, rsp_out_tdata 0, inflight_count 0, err_unknown_id 0.
  - rsp_in_tready stays 0 until S_RUN.
  - job_tdata and rsp_out_tdata hold their last value while the matching valid is low.

## Timing
- From a req handshake in cycle N, job_tvalid=1 in cycle N+1.
- From a rsp_in handshake in cycle N, rsp_out_tvalid=1 in cycle N+1.
- Full throughput of one job per cycle when job_tready=1 continuously. Same for responses.
- Valid/data are held stable until the handshake completes, per AXI-Stream.
- inflight_count is registered and reflects handshakes of the previous cycle.
- ap_start rises one cycle after reset release.

## Structure
- Package ccrf_sched_pkg holds:
  - REQ_W, RSP_W and the JOB_ID field position constants;
  - the FSM state enum;
  - the job ID and requester index typedefs.
- Sub-module ccrf_rr_arbiter: parameterised NUM_REQ round-robin arbiter. It takes a request vector and a pointer, and returns a one-hot grant plus the index. It is purely combinational, and the pointer register lives in the parent.
- The owner table is a 2**JOB_ID_W x REQ_IDX_W flop array. It is not RAM, because it needs same-cycle reads.

## Test plan
- Startup: release reset and pulse ap_ready at cycle 3. Check that ap_start rises at cycle 1 and stays high, that no req_tready appears before S_RUN, and that rsp_in_tready=1 from S_RUN.
- Single job: requester 2 sends TDATA=496'd99 → job_tdata = 99 with bits [3:0] replaced by ID 0, one cycle later. Then kernel response 32'h0000_0A50 → rsp_out_tvalid=4'b0100 and data 32'h0000_0A50, and inflight_count returns to 0.
- Fairness: all 4 requesters valid continuously and job_tready=1 → grants 0,1,2,3,0,… and IDs 0,1,2,… in order.
- Full: 16 jobs accepted with no responses → req_tready=0 and inflight_count=16. One response for ID 5 → the next grant receives ID 5.
- Unknown ID: a response with ID 9 while ID 9 is free → no rsp_out_tvalid, err_unknown_id pulses for exactly one cycle, and rsp_in_tready stays 1.
- Backpressure and reset: hold job_tready=0 and rsp_out_tready=0 → data stays stable and no extra grants. Assert areset mid-transfer → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ccrf_sched_pkg.sv
// Shared constants and types for the CCRF job scheduler slice.
package ccrf_sched_pkg;

  localparam int unsigned CCRF_NUM_REQ   = 4;
  localparam int unsigned CCRF_REQ_IDX_W = 2;
  localparam int unsigned CCRF_JOB_ID_W  = 4;
  localparam int unsigned CCRF_REQ_W     = 496;
  localparam int unsigned CCRF_RSP_W     = 32;

  // Job ID occupies the low bits of both the request and the response word
  localparam int unsigned JOB_ID_LSB     = 0;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } sched_state_t;

  typedef logic [CCRF_JOB_ID_W-1:0]  job_id_t;
  typedef logic [CCRF_REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/ccrf_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr, pointer register lives in the parent.
module ccrf_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccrf_job_scheduler.sv
// Shares one CCRF kernel between requesters: RR arbitration, job ID stamping,
// response routing by echoed ID, and the kernel ap_start handshake.
module ccrf_job_scheduler
  import ccrf_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = CCRF_NUM_REQ,
  parameter int unsigned REQ_IDX_W = CCRF_REQ_IDX_W,
  parameter int unsigned JOB_ID_W  = CCRF_JOB_ID_W,
  parameter int unsigned REQ_W     = CCRF_REQ_W,
  parameter int unsigned RSP_W     = CCRF_RSP_W
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_REQ-1:0]       req_tvalid,
  output logic [NUM_REQ-1:0]       req_tready,
  input  logic [NUM_REQ*REQ_W-1:0] req_tdata,
  output logic                     job_tvalid,
  input  logic                     job_tready,
  output logic [REQ_W-1:0]         job_tdata,
  input  logic                     rsp_in_tvalid,
  output logic                     rsp_in_tready,
  input  logic [RSP_W-1:0]         rsp_in_tdata,
  output logic [NUM_REQ-1:0]       rsp_out_tvalid,
  input  logic [NUM_REQ-1:0]       rsp_out_tready,
  output logic [RSP_W-1:0]         rsp_out_tdata,
  output logic                     ap_start,
  input  logic                     ap_ready,
  input  logic                     ap_idle,
  output logic [JOB_ID_W:0]        inflight_count,
  output logic                     err_unknown_id
);

  localparam int unsigned NUM_JOBS = 2**JOB_ID_W;
  localparam int unsigned CNT_W    = JOB_ID_W + 1;

  sched_state_t         state_q;
  logic                 ap_start_q;
  logic                 run;

  logic [REQ_IDX_W-1:0] rr_ptr_q;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [REQ_IDX_W-1:0] arb_idx;
  logic                 arb_valid;

  logic [NUM_JOBS-1:0]  busy_q;
  logic [NUM_JOBS-1:0]  busy_d;
  logic [REQ_IDX_W-1:0] owner_q [NUM_JOBS];
  logic [JOB_ID_W-1:0]  free_id;
  logic                 free_found;
  logic                 id_avail;

  logic                 job_vld_q;
  logic [REQ_W-1:0]     job_data_q;
  logic [REQ_W-1:0]     job_d;
  logic                 job_drain;
  logic                 do_grant;

  logic                 rsp_vld_q;
  logic [REQ_IDX_W-1:0] rsp_owner_q;
  logic [RSP_W-1:0]     rsp_data_q;
  logic [JOB_ID_W-1:0]  rsp_id;
  logic                 rsp_drain;
  logic                 rsp_accept;
  logic                 rsp_known;
  logic                 rsp_free;

  logic [CNT_W-1:0]     inflight_q;
  logic                 err_q;

  // Kernel idle is informational only
  logic                 unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q    <= S_RESET;
      ap_start_q <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q    <= S_START;
          ap_start_q <= 1'b1;
        end
        S_START: begin
          ap_start_q <= 1'b1;
          if (ap_ready) state_q <= S_RUN;
        end
        S_RUN: begin
          state_q    <= S_RUN;
          ap_start_q <= 1'b1;
        end
        default: begin
          state_q    <= S_RESET;
          ap_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign run      = (state_q == S_RUN);
  assign ap_start = ap_start_q;

  ccrf_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_arb (
    .req         (req_tvalid),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    free_id    = '0;
    free_found = 1'b0;
    for (int unsigned j = 0; j < NUM_JOBS; j++) begin
      if (!free_found && !busy_q[j]) begin
        free_id    = JOB_ID_W'(j);
        free_found = 1'b1;
      end
    end
  end

  assign id_avail   = ~&busy_q;
  assign job_drain  = job_vld_q & job_tready;
  assign do_grant   = run & id_avail & (~job_vld_q | job_drain) & arb_valid;
  assign req_tready = do_grant ? arb_grant : '0;

  always_comb begin
    job_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) job_d = req_tdata[i*REQ_W +: REQ_W];
    end
    job_d[JOB_ID_LSB +: JOB_ID_W] = free_id;
  end

  always_comb begin
    rsp_out_tvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_out_tvalid[i] = rsp_vld_q && (rsp_owner_q == REQ_IDX_W'(i));
    end
  end

  assign rsp_id        = rsp_in_tdata[JOB_ID_LSB +: JOB_ID_W];
  assign rsp_drain     = |(rsp_out_tvalid & rsp_out_tready);
  assign rsp_in_tready = run & (~rsp_vld_q | rsp_drain);
  assign rsp_accept    = rsp_in_tvalid & rsp_in_tready;
  assign rsp_known     = busy_q[rsp_id];
  assign rsp_free      = rsp_accept & rsp_known;

  // Allocated and freed IDs are always distinct: one was free, the other busy
  always_comb begin
    busy_d = busy_q;
    if (rsp_free) busy_d[rsp_id]  = 1'b0;
    if (do_grant) busy_d[free_id] = 1'b1;
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      for (int unsigned j = 0; j < NUM_JOBS; j++) owner_q[j] <= '0;
    end else if (do_grant) begin
      owner_q[free_id] <= arb_idx;
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      job_vld_q   <= 1'b0;
      job_data_q  <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_q + CNT_W'(do_grant) - CNT_W'(rsp_free);
      err_q      <= rsp_accept & ~rsp_known;

      if (do_grant) begin
        rr_ptr_q   <= (arb_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + REQ_IDX_W'(1);
        job_vld_q  <= 1'b1;
        job_data_q <= job_d;
      end else if (job_drain) begin
        job_vld_q  <= 1'b0;
      end

      if (rsp_free) begin
        rsp_vld_q   <= 1'b1;
        rsp_owner_q <= owner_q[rsp_id];
        rsp_data_q  <= rsp_in_tdata;
      end else if (rsp_drain) begin
        rsp_vld_q   <= 1'b0;
      end
    end
  end

  assign job_tvalid     = job_vld_q;
  assign job_tdata      = job_data_q;
  assign rsp_out_tdata  = rsp_data_q;
  assign inflight_count = inflight_q;
  assign err_unknown_id = err_q;

endmodule

// File: tb/tb_ccrf_job_scheduler.sv
// Scoreboard bench for ccrf_job_scheduler: a driver with a behavioural model
// pushes expectations, an independent monitor checks the output streams.
module tb_ccrf_job_scheduler;
  import ccrf_sched_pkg::*;

  localparam int NR = 4;
  localparam int JW = 4;
  localparam int NJ = 16;
  localparam int RW = 496;
  localparam int SW = 32;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NR-1:0]     req_tvalid;
  logic [NR-1:0]     req_tready;
  logic [NR*RW-1:0]  req_tdata;
  logic              job_tvalid;
  logic              job_tready;
  logic [RW-1:0]     job_tdata;
  logic              rsp_in_tvalid;
  logic              rsp_in_tready;
  logic [SW-1:0]     rsp_in_tdata;
  logic [NR-1:0]     rsp_out_tvalid;
  logic [NR-1:0]     rsp_out_tready;
  logic [SW-1:0]     rsp_out_tdata;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_idle;
  logic [JW:0]       inflight_count;
  logic              err_unknown_id;

  ccrf_job_scheduler #(
    .NUM_REQ   (NR),
    .REQ_IDX_W (2),
    .JOB_ID_W  (JW),
    .REQ_W     (RW),
    .RSP_W     (SW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .req_tdata      (req_tdata),
    .job_tvalid     (job_tvalid),
    .job_tready     (job_tready),
    .job_tdata      (job_tdata),
    .rsp_in_tvalid  (rsp_in_tvalid),
    .rsp_in_tready  (rsp_in_tready),
    .rsp_in_tdata   (rsp_in_tdata),
    .rsp_out_tvalid (rsp_out_tvalid),
    .rsp_out_tready (rsp_out_tready),
    .rsp_out_tdata  (rsp_out_tdata),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_idle        (ap_idle),
    .inflight_count (inflight_count),
    .err_unknown_id (err_unknown_id)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [RW-1:0] data; int cyc; } job_exp_t;
  typedef struct { int owner; logic [SW-1:0] data; int cyc; } rsp_exp_t;

  job_exp_t job_q[$];
  rsp_exp_t rsp_q[$];
  int       err_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus knobs, applied to the DUT at each falling edge
  bit            pend [NR];
  logic [RW-1:0] pdata [NR];
  bit            kv;
  logic [SW-1:0] kdata;
  bit            k_job_rdy, k_ap_ready, k_refill;
  logic [NR-1:0] k_rsp_rdy;

  // Reference model state
  bit m_busy [NJ];
  int m_owner [NJ];
  int m_rr, m_count, m_rsp_owner;
  bit m_job_occ, m_rsp_occ, m_started, m_run;

  initial forever begin
    @(negedge aclk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] rand_word();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    return w[RW-1:0];
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NJ; j++) begin
      m_busy[j]  = 1'b0;
      m_owner[j] = 0;
    end
    m_rr = 0; m_count = 0; m_rsp_owner = 0;
    m_job_occ = 0; m_rsp_occ = 0; m_started = 0; m_run = 0;
    job_q.delete(); rsp_q.delete(); err_q.delete();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b0;
    model_clear();
    #1;
    chk("rst_ap_start", ap_start, 0);
    chk("rst_req_tready", req_tready, 0);
    chk("rst_job_tvalid", job_tvalid, 0);
    chk("rst_job_tdata", job_tdata, 0);
    chk("rst_rsp_in_tready", rsp_in_tready, 0);
    chk("rst_rsp_out_tvalid", rsp_out_tvalid, 0);
    chk("rst_rsp_out_tdata", rsp_out_tdata, 0);
    chk("rst_inflight", inflight_count, 0);
    chk("rst_err", err_unknown_id, 0);
    repeat (2) @(negedge aclk);
  endtask

  // One clock: apply knobs, check combinational readies, advance the model
  task automatic step();
    int g, aid;
    logic [JW-1:0] rid;
    logic [NR-1:0] exp_rdy;
    logic [RW-1:0] w;
    bit drain, exp_rin, acc;
    job_exp_t je;
    rsp_exp_t re;
    @(negedge aclk);
    areset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_tvalid[i] = pend[i];
      req_tdata[i*RW +: RW] = pdata[i];
    end
    job_tready = k_job_rdy;
    rsp_out_tready = k_rsp_rdy;
    ap_ready = k_ap_ready;
    rsp_in_tvalid = kv;
    rsp_in_tdata = kdata;
    #1;
    chk("ap_start", ap_start, m_started);
    chk("inflight_count", inflight_count, m_count);

    g = -1;
    if (m_run && m_count < NJ && (!m_job_occ || k_job_rdy))
      for (int k = 0; k < NR; k++)
        if (g < 0 && pend[(m_rr + k) % NR]) g = (m_rr + k) % NR;
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_tready", req_tready, exp_rdy);

    drain = m_rsp_occ && k_rsp_rdy[m_rsp_owner];
    exp_rin = m_run && (!m_rsp_occ || drain);
    chk("rsp_in_tready", rsp_in_tready, exp_rin);
    acc = exp_rin && kv;

    aid = -1;
    if (g >= 0)
      for (int j = 0; j < NJ; j++) if (aid < 0 && !m_busy[j]) aid = j;

    if (m_job_occ && k_job_rdy) m_job_occ = 0;
    if (drain) m_rsp_occ = 0;

    if (acc) begin
      rid = kdata[JW-1:0];
      kv = 0;
      if (m_busy[rid]) begin
        m_busy[rid] = 0;
        m_count--;
        re.owner = m_owner[rid]; re.data = kdata; re.cyc = cyc + 1;
        rsp_q.push_back(re);
        m_rsp_occ = 1;
        m_rsp_owner = m_owner[rid];
      end else begin
        err_q.push_back(cyc + 1);
      end
    end

    if (g >= 0) begin
      w = pdata[g];
      w[JW-1:0] = JW'(aid);
      m_busy[aid] = 1;
      m_owner[aid] = g;
      m_count++;
      je.data = w; je.cyc = cyc + 1;
      job_q.push_back(je);
      m_job_occ = 1;
      m_rr = (g + 1) % NR;
      if (k_refill) pdata[g] = rand_word();
      else pend[g] = 0;
    end

    if (!m_started) m_started = 1;
    else if (!m_run && k_ap_ready) m_run = 1;
  endtask

  task automatic startup(input bit with_reqs);
    for (int i = 0; i < NR; i++) begin
      pend[i] = with_reqs;
      pdata[i] = rand_word();
    end
    k_job_rdy = 1; k_rsp_rdy = '1; k_refill = 0;
    for (int c = 0; c < 6; c++) begin
      k_ap_ready = (c == 3);
      step();
    end
    k_ap_ready = 0;
  endtask

  // Monitor: compares output streams against the scoreboard queues
  initial forever begin
    logic [NR-1:0] erv;
    bit ev, ee;
    @(negedge aclk);
    #2;
    ev = (job_q.size() != 0) && (job_q[0].cyc <= cyc);
    chk("job_tvalid", job_tvalid, ev);
    if (ev && job_tvalid) begin
      chk("job_tdata", job_tdata, job_q[0].data);
      if (job_tready) void'(job_q.pop_front());
    end

    erv = '0;
    if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) erv = NR'(1 << rsp_q[0].owner);
    chk("rsp_out_tvalid", rsp_out_tvalid, erv);
    if (erv != 0 && rsp_out_tvalid == erv) begin
      chk("rsp_out_tdata", rsp_out_tdata, rsp_q[0].data);
      if ((rsp_out_tready & erv) != 0) void'(rsp_q.pop_front());
    end

    ee = (err_q.size() != 0) && (err_q[0] == cyc);
    if (ee) void'(err_q.pop_front());
    chk("err_unknown_id", err_unknown_id, ee);
  end

  initial begin
    int n;
    int cands[$];
    logic [JW-1:0] id;
    areset = 1'b0;
    req_tvalid = '0; req_tdata = '0; job_tready = 0; rsp_in_tvalid = 0;
    rsp_in_tdata = '0; rsp_out_tready = '0; ap_ready = 0; ap_idle = 1;
    for (int i = 0; i < NR; i++) begin pend[i] = 0; pdata[i] = '0; end
    kv = 0; kdata = '0; k_job_rdy = 1; k_ap_ready = 0; k_refill = 0; k_rsp_rdy = '1;
    model_clear();

    // Startup with requests waiting: nothing granted before S_RUN
    do_reset();
    startup(1);
    repeat (4) step();

    // Single job from requester 2, then its response
    do_reset();
    startup(0);
    pend[2] = 1; pdata[2] = RW'(99);
    n = 0;
    while (m_count == 0 && n < 10) begin step(); n++; end
    chk("single_grant_timeout", m_count, 1);
    step();
    kv = 1; kdata = 32'h0000_0A50;
    n = 0;
    while (kv && n < 10) begin step(); n++; end
    chk("single_rsp_timeout", kv, 0);
    repeat (3) step();
    chk("single_inflight_zero", inflight_count, 0);

    // Fairness into full, then free ID 5 and watch it reallocated
    k_refill = 1;
    for (int i = 0; i < NR; i++) begin pend[i] = 1; pdata[i] = rand_word(); end
    repeat (22) step();
    chk("full_inflight", inflight_count, NJ);
    chk("full_req_tready", req_tready, 0);
    kv = 1; kdata = 32'hC0DE_0005;
    n = 0;
    while (kv && n < 10) begin step(); n++; end
    chk("full_rsp_timeout", kv, 0);
    repeat (4) step();
    k_refill = 0;

    // Unknown ID 9 while everything is free
    do_reset();
    startup(0);
    kv = 1; kdata = 32'h5A5A_0009;
    repeat (5) step();

    // Backpressure, then reset with work in flight
    k_job_rdy = 0; k_rsp_rdy = '0;
    pend[1] = 1; pdata[1] = rand_word();
    pend[3] = 1; pdata[3] = rand_word();
    repeat (3) step();
    kv = 1; kdata = 32'h1234_5670;
    repeat (6) step();
    do_reset();
    kv = 1; kdata = 32'h1234_5670;
    startup(0);
    repeat (3) step();

    // Randomised traffic with one reset in the middle
    for (int it = 0; it < 2000; it++) begin
      if (it == 1000) begin
        do_reset();
        startup(0);
      end
      k_job_rdy = ($urandom % 4) != 0;
      k_rsp_rdy = NR'($urandom);
      for (int i = 0; i < NR; i++)
        if (!pend[i] && ($urandom % 3) == 0) begin pend[i] = 1; pdata[i] = rand_word(); end
      if (!kv && ($urandom % 2) == 0) begin
        cands.delete();
        for (int j = 0; j < NJ; j++) if (m_busy[j]) cands.push_back(j);
        if (cands.size() != 0 && ($urandom % 8) != 0)
          id = JW'(cands[$urandom_range(0, cands.size() - 1)]);
        else
          id = JW'($urandom);
        kdata = $urandom;
        kdata[JW-1:0] = id;
        kv = 1;
      end
      step();
    end

    k_job_rdy = 1; k_rsp_rdy = '1;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
